// File: rtl/cs_sequencer_pkg.sv
// Shared types, widths and the round-robin pick for the chip-select sequencer.
package cs_sequencer_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  // Search from last_grant+1 upward, wrapping; nearest set request wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [ID_W-1:0] last_grant);
    logic [ID_W-1:0] id;
    rr_pick = last_grant;
    for (int k = int'(NREQ); k >= 1; k--) begin
      id = last_grant + ID_W'(k);
      if (req[id]) rr_pick = id;
    end
  endfunction

endpackage

// File: rtl/cs_sequencer_ls139.sv
// Dual 2-to-4 active-low decoder with active-low enables (74LS139 equivalent).
module ls139 (
  input  logic       i_n_e0,
  input  logic [1:0] i_a0,
  output logic [3:0] o_n_y0,
  input  logic       i_n_e1,
  input  logic [1:0] i_a1,
  output logic [3:0] o_n_y1
);

  assign o_n_y0 = i_n_e0 ? 4'hF : ~(4'b0001 << i_a0);
  assign o_n_y1 = i_n_e1 ? 4'hF : ~(4'b0001 << i_a1);

endmodule

// File: rtl/cs_sequencer.sv
// Round-robin chip-select sequencer: arbitrates four requesters onto one
// shared decoder with programmable setup, strobe and recovery windows.
module cs_sequencer
  import cs_sequencer_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 2,
  parameter int unsigned RECOVER_CYC = 1
) (
  input  logic            clk_49m,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [ID_W-1:0] sel_a,
  output logic            sel_n_e,
  output logic [NREQ-1:0] n_cs,
  output logic            busy,
  output logic [ID_W-1:0] grant_id
);

  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

  if (SETUP_CYC < 1 || SETUP_CYC > CNT_MAX) begin : g_bad_setup
    $error("cs_sequencer: SETUP_CYC must be in 1..15");
  end
  if (STROBE_CYC < 1 || STROBE_CYC > CNT_MAX) begin : g_bad_strobe
    $error("cs_sequencer: STROBE_CYC must be in 1..15");
  end
  if (RECOVER_CYC < 1 || RECOVER_CYC > CNT_MAX) begin : g_bad_recover
    $error("cs_sequencer: RECOVER_CYC must be in 1..15");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_sel_a;
  logic             r_sel_n_e;
  logic [NREQ-1:0]  r_ack;
  logic             r_busy;
  logic [ID_W-1:0]  r_grant_id;
  logic [ID_W-1:0]  r_last_grant;

  logic [ID_W-1:0]  w_pick;
  logic [NREQ-1:0]  w_grant_onehot;
  logic [3:0]       w_n_y1_unused;

  assign w_pick         = rr_pick(req, r_last_grant);
  assign w_grant_onehot = NREQ'(1) << r_grant_id;

  // ack is registered so it lands on the final strobe cycle, hence the
  // look-ahead: it is loaded on the edge that enters that cycle.
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sel_a      <= '0;
      r_sel_n_e    <= 1'b1;
      r_ack        <= '0;
      r_busy       <= 1'b0;
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(NREQ - 1);
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_grant_id <= w_pick;
            r_sel_a    <= w_pick;
            r_cnt      <= CNT_W'(SETUP_CYC - 1);
            r_busy     <= 1'b1;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_cnt     <= CNT_W'(STROBE_CYC - 1);
            r_sel_n_e <= 1'b0;
            r_state   <= STROBE;
            if (STROBE_CYC == 1) r_ack <= w_grant_onehot;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        STROBE: begin
          if (r_cnt == '0) begin
            r_cnt     <= CNT_W'(RECOVER_CYC - 1);
            r_sel_n_e <= 1'b1;
            r_state   <= RECOVER;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_ack <= w_grant_onehot;
          end
        end
        RECOVER: begin
          if (r_cnt == '0) begin
            r_last_grant <= r_grant_id;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Only half 0 drives the chip selects; half 1 is held disabled.
  ls139 u_ls139 (
    .i_n_e0 (r_sel_n_e),
    .i_a0   (r_sel_a),
    .o_n_y0 (n_cs),
    .i_n_e1 (1'b1),
    .i_a1   (2'b00),
    .o_n_y1 (w_n_y1_unused)
  );

  assign ack      = r_ack;
  assign sel_a    = r_sel_a;
  assign sel_n_e  = r_sel_n_e;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_cs_sequencer.sv
// Self-checking bench for cs_sequencer: transaction-level model plus directed
// scenarios on a default-parameter and a (3,1,2)-parameter instance.
module tb_cs_sequencer;

  logic       clk_49m = 1'b0;
  logic       reset;
  logic [3:0] req, req_p;

  logic [3:0] ack, n_cs, p_ack, p_n_cs;
  logic [1:0] sel_a, grant_id, p_sel_a, p_grant_id;
  logic       sel_n_e, busy, p_sel_n_e, p_busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk_49m = ~clk_49m;
  always @(posedge clk_49m) cyc++;

  cs_sequencer dut (
    .clk_49m(clk_49m), .reset(reset), .req(req), .ack(ack), .sel_a(sel_a),
    .sel_n_e(sel_n_e), .n_cs(n_cs), .busy(busy), .grant_id(grant_id)
  );

  cs_sequencer #(.SETUP_CYC(3), .STROBE_CYC(1), .RECOVER_CYC(2)) dut_p (
    .clk_49m(clk_49m), .reset(reset), .req(req_p), .ack(p_ack), .sel_a(p_sel_a),
    .sel_n_e(p_sel_n_e), .n_cs(p_n_cs), .busy(p_busy), .grant_id(p_grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase counts cycles since the grant edge (1-based).
  typedef struct packed {
    logic       active;
    logic [7:0] phase;
    logic [1:0] gid;
    logic [1:0] last;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.active = 1'b0; m.phase = 8'd0; m.gid = 2'd0; m.last = 2'd3;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, logic [3:0] r, int s, int t, int rc);
    model_t n;
    int     id;
    bit     found;
    n = m;
    found = 1'b0;
    if (m.active) begin
      if (int'(m.phase) == s + t + rc) begin
        n.active = 1'b0;
        n.last   = m.gid;
      end else begin
        n.phase = m.phase + 8'd1;
      end
    end else if (r != 4'd0) begin
      for (int off = 1; off <= 4; off++) begin
        id = (int'(m.last) + off) % 4;
        if (!found && r[id]) begin
          found = 1'b1;
          n.gid = 2'(id);
        end
      end
      n.active = 1'b1;
      n.phase  = 8'd1;
    end
    return n;
  endfunction

  function automatic logic in_strobe(model_t m, int s, int t);
    return m.active && int'(m.phase) > s && int'(m.phase) <= s + t;
  endfunction

  function automatic logic [3:0] exp_ack(model_t m, int s, int t);
    return (m.active && int'(m.phase) == s + t) ? 4'(1 << m.gid) : 4'd0;
  endfunction

  function automatic logic [3:0] exp_ncs(model_t m, int s, int t);
    return in_strobe(m, s, t) ? ~4'(1 << m.gid) : 4'hF;
  endfunction

  model_t m0, mp;

  always @(posedge clk_49m) begin
    if (reset) begin
      m0 = model_reset();
      mp = model_reset();
    end else begin
      m0 = model_step(m0, req,   1, 2, 1);
      mp = model_step(mp, req_p, 3, 1, 2);
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk_49m) begin
    if (!reset) begin
      check("m_ack",      ack,      exp_ack(m0, 1, 2));
      check("m_n_cs",     n_cs,     exp_ncs(m0, 1, 2));
      check("m_sel_n_e",  sel_n_e,  !in_strobe(m0, 1, 2));
      check("m_busy",     busy,     m0.active);
      check("m_grant_id", grant_id, m0.gid);
      check("m_sel_a",    sel_a,    m0.gid);
      check("p_ack",      p_ack,    exp_ack(mp, 3, 1));
      check("p_n_cs",     p_n_cs,   exp_ncs(mp, 3, 1));
      check("p_sel_n_e",  p_sel_n_e, !in_strobe(mp, 3, 1));
      check("p_busy",     p_busy,   mp.active);
      check("p_grant_id", p_grant_id, mp.gid);
    end
  end

  int p_low_q[$];
  always @(negedge clk_49m) begin
    if (!reset && p_sel_n_e == 1'b0) p_low_q.push_back(cyc);
  end

  task automatic cyc1();
    @(posedge clk_49m);
    #1;
  endtask

  function automatic int onehot_id(logic [3:0] v);
    int id;
    id = -1;
    for (int i = 0; i < 4; i++) if (v[i]) id = i;
    return id;
  endfunction

  int p_c0;
  int ids[$];
  int acyc[$];

  initial begin
    reset = 1'b1;
    req   = 4'd0;
    req_p = 4'd0;
    repeat (3) cyc1();
    check("rst_n_cs",     n_cs,     4'hF);
    check("rst_sel_n_e",  sel_n_e,  1'b1);
    check("rst_ack",      ack,      4'd0);
    check("rst_busy",     busy,     1'b0);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_sel_a",    sel_a,    2'd0);
    reset = 1'b0;
    req_p = 4'b1000;
    p_c0  = cyc;

    // All requests held: grants 0,1,2,3,0 every 5 cycles.
    req = 4'hF;
    for (int k = 1; k <= 25; k++) begin
      cyc1();
      if (ack != 4'd0) begin
        check("all_onehot", $countones(ack), 1);
        ids.push_back(onehot_id(ack));
        acyc.push_back(k);
      end
    end
    req = 4'd0;
    check("all_count", ids.size(), 5);
    check("all_first_ack_cycle", acyc[0], 3);
    for (int i = 0; i < 5; i++) begin
      if (i < ids.size()) begin
        check("all_order",   ids[i], i % 4);
        check("all_spacing", acyc[i] - acyc[0], 5 * i);
      end
    end
    repeat (8) cyc1();

    // Single request on requester 0.
    req = 4'b0001;
    cyc1();
    check("s_busy_c1",  busy,    1'b1);
    check("s_sel_a_c1", sel_a,   2'd0);
    check("s_ncs_c1",   n_cs,    4'hF);
    check("s_nen_c1",   sel_n_e, 1'b1);
    cyc1();
    check("s_ncs_c2",   n_cs,    4'b1110);
    check("s_ack_c2",   ack,     4'd0);
    cyc1();
    check("s_ncs_c3",   n_cs,    4'b1110);
    check("s_ack_c3",   ack,     4'b0001);
    req = 4'd0;
    cyc1();
    check("s_ncs_c4",   n_cs,    4'hF);
    check("s_busy_c4",  busy,    1'b1);
    check("s_ack_c4",   ack,     4'd0);
    cyc1();
    check("s_busy_c5",  busy,    1'b0);

    // Requester 2 drops its request during SETUP.
    req = 4'b0100;
    cyc1();
    check("d_sel_a", sel_a, 2'd2);
    req = 4'd0;
    cyc1();
    check("d_ncs_c2", n_cs, 4'b1011);
    cyc1();
    check("d_ncs_c3", n_cs, 4'b1011);
    check("d_ack_c3", ack,  4'b0100);
    cyc1();
    cyc1();
    check("d_idle", busy, 1'b0);

    // Make last_grant = 1, then race requesters 1 and 3.
    req = 4'b0010;
    repeat (3) cyc1();
    req = 4'd0;
    repeat (2) cyc1();
    check("rr_last1", grant_id, 2'd1);
    ids.delete();
    req = 4'b1010;
    for (int k = 1; k <= 14; k++) begin
      cyc1();
      if (ack != 4'd0) begin
        ids.push_back(onehot_id(ack));
        req = req & ~ack;
      end
    end
    req = 4'd0;
    check("rr_count",  ids.size(), 2);
    check("rr_first",  ids[0], 3);
    check("rr_second", ids[1], 1);

    // Parameter instance (3,1,2): one-cycle strobe, 4 cycles in, period 7.
    check("p_first_low", p_low_q[0], p_c0 + 4);
    check("p_period",    p_low_q[1] - p_low_q[0], 7);
    check("p_width",     p_low_q[2] - p_low_q[1], 7);

    // Reset asserted in the middle of a strobe.
    repeat (2) cyc1();
    req = 4'b0001;
    cyc1();
    cyc1();
    check("r_pre_ncs", n_cs, 4'b1110);
    reset = 1'b1;
    #1;
    check("r_ncs",     n_cs,    4'hF);
    check("r_sel_n_e", sel_n_e, 1'b1);
    check("r_ack",     ack,     4'd0);
    req = 4'd0;
    cyc1();
    cyc1();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc1();
      check("r_no_ack", ack,  4'd0);
      check("r_idle",   busy, 1'b0);
    end

    // Random traffic checked by the model.
    for (int k = 0; k < 800; k++) begin
      cyc1();
      req   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      req_p = 4'($urandom);
    end
    req   = 4'd0;
    req_p = 4'd0;
    repeat (10) cyc1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
